// File: rtl/reg_file_sweep_if.sv
// Operand bus between decode and the register file: write port, two read ports, status.
interface reg_file_sweep_if #(
  parameter int W = 16,
  parameter int D = 4
);
  logic         clear;
  logic         write_en;
  logic [D-1:0] waddr;
  logic [W-1:0] data_in;
  logic [D-1:0] raddrA;
  logic [D-1:0] rAddrB;
  logic         imm_sel;
  logic [W-1:0] immValue;
  logic [W-1:0] data_outA;
  logic [W-1:0] data_outB;
  logic         busy;
  logic         wr_drop;

  modport master (
    output clear, write_en, waddr, data_in, raddrA, rAddrB, imm_sel, immValue,
    input  data_outA, data_outB, busy, wr_drop
  );

  modport slave (
    input  clear, write_en, waddr, data_in, raddrA, rAddrB, imm_sel, immValue,
    output data_outA, data_outB, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_sweep.sv
// Parametrised register file: 2 combinational reads, 1 clocked write, FSM clear sweep.
// Optional write-through forwarding when REG_FILE_WR_BYPASS_EN is defined.
module reg_file_sweep #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  reg_file_sweep_if.slave bus
);
  localparam int           DEPTH    = 2 ** D;
  localparam logic [D-1:0] LAST_PTR = D'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e       state_q, state_d;
  logic [D-1:0] sweep_ptr_q, sweep_ptr_d;
  logic         wr_drop_q, wr_drop_d;
  logic         wr_req;
  logic         wr_fire;
  logic [W-1:0] regs_q [DEPTH];

  assign wr_req  = bus.write_en && (bus.waddr != '0);
  assign wr_fire = wr_req && (state_q == ST_READY) && !bus.clear;

  // NOTE: non-blocking assignments in clocked processes so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_CLEAR;
      sweep_ptr_q <= '0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  // NOTE: the array has no reset; the clear sweep zeroes it, which keeps
  // the storage a plain flop/RAM array without per-bit reset wiring.
  always_ff @(posedge CLK) begin
    if (state_q == ST_CLEAR) begin
      regs_q[sweep_ptr_q] <= '0;
    end else if (wr_fire) begin
      regs_q[bus.waddr] <= bus.data_in;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    wr_drop_d   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        wr_drop_d = wr_req;
        if (sweep_ptr_q == LAST_PTR) begin
          state_d     = ST_READY;
          sweep_ptr_d = '0;
        end else begin
          sweep_ptr_d = sweep_ptr_q + D'(1);
        end
      end
      ST_READY: begin
        if (bus.clear) begin
          wr_drop_d   = wr_req;
          state_d     = ST_CLEAR;
          sweep_ptr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == ST_CLEAR);
    bus.wr_drop   = wr_drop_q;
    bus.data_outA = '0;
    bus.data_outB = bus.imm_sel ? bus.immValue : '0;
    if (state_q == ST_READY) begin
      bus.data_outA = regs_q[bus.raddrA];
      if (!bus.imm_sel) bus.data_outB = regs_q[bus.rAddrB];
`ifdef REG_FILE_WR_BYPASS_EN
      // wr_fire already excludes waddr 0 and clear, so register 0 never forwards
      if (wr_fire && (bus.raddrA == bus.waddr)) bus.data_outA = bus.data_in;
      if (wr_fire && !bus.imm_sel && (bus.rAddrB == bus.waddr)) bus.data_outB = bus.data_in;
`endif
    end
  end
endmodule

// File: tb/tb_reg_file_sweep.sv
// Directed bench for reg_file_sweep: sweep timing, reads/writes, drops, reset mid-sweep.
module tb_reg_file_sweep;
  localparam int W = 16;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST_N;
  int   checks   = 0;
  int   failures = 0;

  reg_file_sweep_if #(.W(W), .D(D)) bus ();

  reg_file_sweep #(.W(W), .D(D)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] exp_fwd;

    RST_N        = 1'b0;
    bus.clear    = 1'b0;
    bus.write_en = 1'b0;
    bus.waddr    = '0;
    bus.data_in  = '0;
    bus.raddrA   = '0;
    bus.rAddrB   = '0;
    bus.imm_sel  = 1'b0;
    bus.immValue = '0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
    check("rst_outA", 32'(bus.data_outA), 32'h0);
    check("rst_outB", 32'(bus.data_outB), 32'h0);
    bus.imm_sel  = 1'b1;
    bus.immValue = 16'h1357;
    #1;
    check("rst_outB_imm", 32'(bus.data_outB), 32'h1357);
    bus.imm_sel = 1'b0;
    tick();
    tick();

    // Release reset and measure the initial sweep
    RST_N      = 1'b1;
    bus.raddrA = 4'd5;
    #1;
    check("sweep_outA_zero", 32'(bus.data_outA), 32'h0);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("init_sweep_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      bus.raddrA = D'(i);
      #1;
      check($sformatf("init_zero_r%0d", i), 32'(bus.data_outA), 32'h0);
    end

    // Write BEEF to r5
    bus.write_en = 1'b1;
    bus.waddr    = 4'd5;
    bus.data_in  = 16'hBEEF;
    bus.raddrA   = 4'd5;
`ifdef REG_FILE_WR_BYPASS_EN
    exp_fwd = 16'hBEEF;
`else
    exp_fwd = 16'h0000;
`endif
    #1;
    check("r5_same_cycle", 32'(bus.data_outA), 32'(exp_fwd));
    tick();
    bus.write_en = 1'b0;
    bus.rAddrB   = 4'd5;
    #1;
    check("r5_outA", 32'(bus.data_outA), 32'hBEEF);
    check("r5_outB", 32'(bus.data_outB), 32'hBEEF);
    check("r5_no_drop", 32'(bus.wr_drop), 32'd0);

    // Write to r0 is silently ignored
    bus.write_en = 1'b1;
    bus.waddr    = 4'd0;
    bus.data_in  = 16'h1234;
    bus.raddrA   = 4'd0;
    #1;
    check("r0_same_cycle", 32'(bus.data_outA), 32'h0);
    tick();
    bus.write_en = 1'b0;
    #1;
    check("r0_reads_zero", 32'(bus.data_outA), 32'h0);
    check("r0_no_drop", 32'(bus.wr_drop), 32'd0);

    // Immediate select on port B
    bus.write_en = 1'b1;
    bus.waddr    = 4'd3;
    bus.data_in  = 16'h00AA;
    tick();
    bus.write_en = 1'b0;
    bus.rAddrB   = 4'd3;
    bus.imm_sel  = 1'b1;
    bus.immValue = 16'h0000;
    #1;
    check("imm_zero", 32'(bus.data_outB), 32'h0);
    bus.imm_sel = 1'b0;
    #1;
    check("r3_outB", 32'(bus.data_outB), 32'h00AA);
    bus.imm_sel  = 1'b1;
    bus.immValue = 16'hFFFF;
    #1;
    check("imm_ffff", 32'(bus.data_outB), 32'hFFFF);
    bus.imm_sel = 1'b0;

    // Forwarding (or not) of a same-cycle write to r4
    bus.write_en = 1'b1;
    bus.waddr    = 4'd4;
    bus.data_in  = 16'h1111;
    tick();
    bus.data_in  = 16'hA5A5;
    bus.raddrA   = 4'd4;
    bus.rAddrB   = 4'd4;
`ifdef REG_FILE_WR_BYPASS_EN
    exp_fwd = 16'hA5A5;
`else
    exp_fwd = 16'h1111;
`endif
    #1;
    check("r4_fwd_A", 32'(bus.data_outA), 32'(exp_fwd));
    check("r4_fwd_B", 32'(bus.data_outB), 32'(exp_fwd));
    bus.imm_sel  = 1'b1;
    bus.immValue = 16'h0F0F;
    #1;
    check("r4_imm_wins", 32'(bus.data_outB), 32'h0F0F);
    bus.imm_sel = 1'b0;
    tick();
    bus.write_en = 1'b0;
    #1;
    check("r4_next_cycle", 32'(bus.data_outA), 32'hA5A5);

    // Write r7, then a write colliding with clear is dropped
    bus.write_en = 1'b1;
    bus.waddr    = 4'd7;
    bus.data_in  = 16'h7777;
    tick();
    bus.data_in = 16'h5555;
    bus.clear   = 1'b1;
    bus.raddrA  = 4'd7;
    #1;
    check("r7_clear_no_fwd", 32'(bus.data_outA), 32'h7777);
    tick();
    check("clr_busy", 32'(bus.busy), 32'd1);
    check("clr_wr_drop", 32'(bus.wr_drop), 32'd1);
    check("clr_outA_zero", 32'(bus.data_outA), 32'h0);
    // Write during the sweep, with clear held (must be ignored)
    bus.waddr   = 4'd9;
    bus.data_in = 16'h9999;
    tick();
    bus.write_en = 1'b0;
    bus.clear    = 1'b0;
    check("sweep_wr_drop", 32'(bus.wr_drop), 32'd1);
    tick();
    check("sweep_drop_clears", 32'(bus.wr_drop), 32'd0);
    n = 2;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("clear_sweep_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      bus.raddrA = D'(i);
      #1;
      check($sformatf("clr_zero_r%0d", i), 32'(bus.data_outA), 32'h0);
    end

    // Reset at sweep cycle 9 restarts a full sweep; clear mid-sweep does not extend it
    bus.write_en = 1'b1;
    bus.waddr    = 4'd2;
    bus.data_in  = 16'h2222;
    tick();
    bus.write_en = 1'b0;
    bus.clear    = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    RST_N = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd1);
    check("midrst_wr_drop", 32'(bus.wr_drop), 32'd0);
    tick();
    RST_N = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      bus.clear = (n == 5);
      tick();
      n++;
    end
    bus.clear = 1'b0;
    check("restart_sweep_len", 32'(n), 32'd16);
    bus.raddrA = 4'd2;
    #1;
    check("restart_r2_zero", 32'(bus.data_outA), 32'h0);
    tick();
    check("ready_stays", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
